// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the LEGv8 instruction-memory loader.
package instruction_memory_loader_pkg;

   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned WORD_W          = 32;
   localparam int unsigned BYTES_PER_WORD  = 4;
   localparam int unsigned IMEM_ADDR_SHIFT = 2;

   // Loader sequencing states; CHECK is only reachable in the checksum build.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_CHECK = 3'd3,
      ST_DONE  = 3'd4
   } loader_state_t;

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Byte-stream input and imem write port of the loader.
// master = loader side, slave = stream source / instruction memory side.
interface instruction_memory_loader_if;
   import instruction_memory_loader_pkg::*;

   logic [BYTE_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [WORD_W-1:0] imem_addr;
   logic [WORD_W-1:0] imem_wdata;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, imem_we, imem_addr, imem_wdata
   );

endinterface

// File: rtl/instruction_memory_loader_byte_packer.sv
// Big-endian byte-to-word packer: first byte lands in bits [31:24].
// word_ready pulses for one cycle after the 4th byte of a word is shifted in.
module loader_byte_packer
   import instruction_memory_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [BYTE_W-1:0] byte_in,
   output logic [WORD_W-1:0] word,
   output logic [1:0]        byte_cnt,
   output logic              word_ready
);

   // Shift register, byte counter and completed-word flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         word       <= '0;
         byte_cnt   <= '0;
         word_ready <= 1'b0;
      end else begin
         word_ready <= 1'b0;
         if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
         end else if (shift_en) begin
            word       <= {word[WORD_W-BYTE_W-1:0], byte_in};
            byte_cnt   <= byte_cnt + 2'd1;
            word_ready <= (byte_cnt == 2'(BYTES_PER_WORD - 1));
         end
      end
   end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction-memory loader: packs a byte stream into 32-bit words, writes
// them to imem from word 0 upward and holds the datapath in reset until done.
// Optional feature macro: CHECKSUM_EN (trailing modulo-256 checksum byte).
module instruction_memory_loader
   import instruction_memory_loader_pkg::*;
#(
   parameter int unsigned ADDR_W = 8
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_W:0]      load_len,
   instruction_memory_loader_if.master bus,
   output logic                 cpu_reset_hold,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   loader_state_t     state;
   logic [ADDR_W-1:0] word_idx;
   logic [ADDR_W:0]   len_q;
   logic              byte_ready_q;
   logic [WORD_W-1:0] imem_addr_q;
   logic [WORD_W-1:0] packed_word;
   logic [1:0]        byte_cnt;
   logic              word_ready;
`ifdef CHECKSUM_EN
   logic [BYTE_W-1:0] sum;
`endif

   logic transfer_c;
   logic idle_c;
   logic clear_c;
   logic shift_c;
   logic last_word_c;

   // Handshake decode and packer control.
   assign transfer_c  = byte_ready_q & bus.byte_valid;
   assign idle_c      = (state == ST_IDLE) || (state == ST_DONE);
   assign clear_c     = idle_c && start && (load_len != '0) && (load_len <= MAX_LEN);
   assign shift_c     = transfer_c && (state == ST_RECV);
   assign last_word_c = (({1'b0, word_idx} + (ADDR_W+1)'(1)) == len_q);

   loader_byte_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear_c),
      .shift_en   (shift_c),
      .byte_in    (bus.byte_in),
      .word       (packed_word),
      .byte_cnt   (byte_cnt),
      .word_ready (word_ready)
   );

   // The packer's completed-word pulse is the write strobe; its register is the data.
   assign bus.byte_ready = byte_ready_q;
   assign bus.imem_we    = word_ready;
   assign bus.imem_addr  = imem_addr_q;
   assign bus.imem_wdata = packed_word;

   // Load sequencer with registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ST_IDLE;
         word_idx       <= '0;
         len_q          <= '0;
         byte_ready_q   <= 1'b0;
         imem_addr_q    <= '0;
         cpu_reset_hold <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
         error          <= 1'b0;
`ifdef CHECKSUM_EN
         sum            <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  if (load_len == '0) begin
                     state          <= ST_DONE;
                     done           <= 1'b1;
                     error          <= 1'b0;
                     cpu_reset_hold <= 1'b0;
                  end else if (load_len > MAX_LEN) begin
                     state          <= ST_IDLE;
                     done           <= 1'b0;
                     error          <= 1'b1;
                     cpu_reset_hold <= 1'b1;
                  end else begin
                     state          <= ST_RECV;
                     done           <= 1'b0;
                     error          <= 1'b0;
                     cpu_reset_hold <= 1'b1;
                     busy           <= 1'b1;
                     byte_ready_q   <= 1'b1;
                     word_idx       <= '0;
                     len_q          <= load_len;
`ifdef CHECKSUM_EN
                     sum            <= '0;
`endif
                  end
               end
            end

            ST_RECV: begin
               if (transfer_c) begin
`ifdef CHECKSUM_EN
                  sum <= sum + bus.byte_in;
`endif
                  if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                     state        <= ST_WRITE;
                     byte_ready_q <= 1'b0;
                     imem_addr_q  <= WORD_W'(word_idx) << IMEM_ADDR_SHIFT;
                  end
               end
            end

            ST_WRITE: begin
               word_idx <= word_idx + ADDR_W'(1);
               if (last_word_c) begin
`ifdef CHECKSUM_EN
                  state        <= ST_CHECK;
                  byte_ready_q <= 1'b1;
`else
                  state          <= ST_DONE;
                  busy           <= 1'b0;
                  done           <= 1'b1;
                  cpu_reset_hold <= 1'b0;
`endif
               end else begin
                  state        <= ST_RECV;
                  byte_ready_q <= 1'b1;
               end
            end

`ifdef CHECKSUM_EN
            ST_CHECK: begin
               if (transfer_c) begin
                  state        <= ST_DONE;
                  byte_ready_q <= 1'b0;
                  busy         <= 1'b0;
                  if (bus.byte_in == sum) begin
                     done           <= 1'b1;
                     cpu_reset_hold <= 1'b0;
                  end else begin
                     error <= 1'b1;
                  end
               end
            end
`endif

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader with a byte-stream model of
// the expected imem writes and a per-cycle write/status checker.
module tb_instruction_memory_loader;
   import instruction_memory_loader_pkg::*;

   localparam int unsigned ADDR_W = 8;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic [ADDR_W:0] load_len = '0;
   logic            cpu_reset_hold, busy, done, error;

   instruction_memory_loader_if bus();

   instruction_memory_loader #(.ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .load_len       (load_len),
      .bus            (bus),
      .cpu_reset_hold (cpu_reset_hold),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  prog[$];
   logic [31:0] exp_addr_q[$], exp_data_q[$];
   logic [31:0] got_addr_q[$], got_data_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Expected writes: word k at byte address 4k, assembled big-endian.
   task automatic model_program(input int words);
      for (int k = 0; k < words; k++) begin
         exp_addr_q.push_back(32'(k * 4));
         exp_data_q.push_back({prog[4*k], prog[4*k+1], prog[4*k+2], prog[4*k+3]});
      end
   endtask

   function automatic logic [7:0] model_sum(input int words);
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 4 * words; i++) s = s + prog[i];
      return s;
   endfunction

   // Compare process: every observed write must match the next modelled write.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         got_addr_q.push_back(bus.imem_addr);
         got_data_q.push_back(bus.imem_wdata);
         if (exp_addr_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %h data %h, expected no write", bus.imem_addr, bus.imem_wdata);
         end else begin
            check("write_addr", bus.imem_addr, exp_addr_q.pop_front());
            check("write_data", bus.imem_wdata, exp_data_q.pop_front());
         end
      end
      if (reset === 1'b1 && busy === 1'b1)
         check("busy_implies_hold", 32'(cpu_reset_hold), 32'd1);
      if (reset === 1'b1 && done === 1'b1)
         check("done_implies_release", 32'(cpu_reset_hold), 32'd0);
   end

   task automatic pulse_start(input int len);
      @(negedge clk);
      start    = 1'b1;
      load_len = (ADDR_W+1)'(len);
      @(negedge clk);
      start    = 1'b0;
   endtask

   // Drive all of prog; mode 1 toggles byte_valid every cycle; poke_idx pulses start mid-load.
   task automatic send_bytes(input int mode, input int poke_idx);
      int  i = 0;
      int  cyc = 0;
      bit  poked = 1'b0;
      logic v;
      while (i < prog.size() && cyc < 20000) begin
         @(negedge clk);
         start = 1'b0;
         if (i == poke_idx && !poked) begin
            start    = 1'b1;
            load_len = '0;
            poked    = 1'b1;
         end
         v = (mode == 0) || (cyc % 2 == 0);
         bus.byte_in    = prog[i];
         bus.byte_valid = v;
         if (v && bus.byte_ready === 1'b1) i++;
         cyc++;
      end
      @(negedge clk);
      start          = 1'b0;
      bus.byte_valid = 1'b0;
      check("stream_consumed", 32'(i), 32'(prog.size()));
   endtask

   task automatic wait_end();
      int n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("load_finished", 32'(done | error), 32'd1);
   endtask

   task automatic expect_status(input string tag, input logic d, input logic h,
                                input logic e, input logic b, input logic r);
      check({tag, "_done"},  32'(done),           32'(d));
      check({tag, "_hold"},  32'(cpu_reset_hold), 32'(h));
      check({tag, "_error"}, 32'(error),          32'(e));
      check({tag, "_busy"},  32'(busy),           32'(b));
      check({tag, "_ready"}, 32'(bus.byte_ready), 32'(r));
   endtask

   // Load prog exactly as given (no checksum byte appended).
   task automatic load_raw(input int len, input int mode, input int poke_idx);
      got_addr_q.delete();
      got_data_q.delete();
      model_program(len);
      pulse_start(len);
      send_bytes(mode, poke_idx);
      wait_end();
      check("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
   endtask

   task automatic run_load(input int len, input int mode, input int poke_idx);
`ifdef CHECKSUM_EN
      prog.push_back(model_sum(len));
`endif
      load_raw(len, mode, poke_idx);
   endtask

   initial begin
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_we",    32'(bus.imem_we), 32'd0);
      check("rst_addr",  bus.imem_addr,    32'd0);
      check("rst_wdata", bus.imem_wdata,   32'd0);
      expect_status("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;

      // Two-word program with literal expectations.
      prog = '{8'hF8, 8'h00, 8'h00, 8'h00, 8'h8B, 8'h02, 8'h00, 8'h41};
      run_load(2, 0, -1);
      check("lit_count", 32'(got_addr_q.size()), 32'd2);
      if (got_addr_q.size() >= 2) begin
         check("lit_addr0", got_addr_q[0], 32'h0000_0000);
         check("lit_data0", got_data_q[0], 32'hF800_0000);
         check("lit_addr1", got_addr_q[1], 32'h0000_0004);
         check("lit_data1", got_data_q[1], 32'h8B02_0041);
      end
      expect_status("lit", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Oversize length: error, back in reset hold; stray valid bytes are not taken.
      pulse_start((1 << ADDR_W) + 1);
      expect_status("big", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ready", 32'(bus.byte_ready), 32'd0);
      bus.byte_valid = 1'b0;

      // Zero length: done one cycle after start, no writes.
      pulse_start(0);
      expect_status("zero", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Toggling byte_valid.
      prog = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
               8'h01, 8'h23, 8'h45, 8'h67};
      run_load(3, 1, -1);
      expect_status("tog", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // start pulsed mid-load is ignored.
      prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(2, 0, 3);
      check("poke_count", 32'(got_addr_q.size()), 32'd2);
      expect_status("poke", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset mid-RECV, then a fresh load.
      prog = '{8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h55};
      got_addr_q.delete();
      got_data_q.delete();
      model_program(1);
      pulse_start(2);
      send_bytes(0, -1);
      check("midrst_word0", (got_data_q.size() > 0) ? got_data_q[0] : 32'h0, 32'hCAFE_BABE);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_we",    32'(bus.imem_we), 32'd0);
      check("midrst_addr",  bus.imem_addr,    32'd0);
      check("midrst_wdata", bus.imem_wdata,   32'd0);
      expect_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      prog = '{8'h91, 8'h00, 8'h03, 8'hE0, 8'hD6, 8'h5F, 8'h03, 8'hC0};
      run_load(2, 0, -1);
      expect_status("fresh", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Full-depth program.
      prog.delete();
      for (int i = 0; i < 4 * (1 << ADDR_W); i++) prog.push_back(8'(i * 13 + 5));
      run_load(1 << ADDR_W, 0, -1);
      check("max_count", 32'(got_addr_q.size()), 32'(1 << ADDR_W));
      if (got_addr_q.size() > 0)
         check("max_last_addr", got_addr_q[got_addr_q.size()-1], 32'h0000_03FC);
      expect_status("max", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
      // Checksum match and mismatch.
      prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      load_raw(1, 0, -1);
      expect_status("csum_ok", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      prog = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
      load_raw(1, 0, -1);
      expect_status("csum_bad", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
